// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers and mode constants for the flagged synchronous FIFO.
package fifo_pkg;
  localparam int FIFO_STD = 0;
  localparam int FIFO_FWFT = 1;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  localparam int PTR_W = clog2(16) + 1;
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: register array with one write port and one asynchronous read port.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 16
) (
  input  logic                clk,
  input  logic                we,
  input  logic [clog2(D)-1:0] waddr,
  input  logic [W-1:0]        wdata,
  input  logic [clog2(D)-1:0] raddr,
  output logic [W-1:0]        rdata
);
  logic [W-1:0] mem [D];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with count, threshold flags, error pulses and optional FWFT read.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 16,
  parameter int AF_THRESH = D - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT = FIFO_STD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [W-1:0]         data_in,
  input  logic                 rd_en,
  output logic [W-1:0]         data_out,
  output logic                 FULL,
  output logic                 EMPTY,
  output logic                 ALMOST_FULL,
  output logic                 ALMOST_EMPTY,
  output logic [$clog2(D):0]   count,
  output logic                 OVERFLOW,
  output logic                 UNDERFLOW
);
  localparam int AW = clog2(D);
  localparam int PW = AW + 1;
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, cnt_n;
  logic          wr_acc, rd_acc;
  logic [W-1:0]  rdata, data_q;
  assign rd_acc = rd_en & ~EMPTY;
  assign wr_acc = wr_en & (~FULL | rd_acc);
  assign wr_ptr_n = wr_ptr + PW'(wr_acc);
  assign rd_ptr_n = rd_ptr + PW'(rd_acc);
  assign cnt_n = wr_ptr_n - rd_ptr_n;
  fifo_ram #(.W(W), .D(D)) u_ram (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(data_in),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(rdata)
  );
  // FWFT keeps a copy of the visible head so data_out holds once the FIFO drains
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      EMPTY        <= 1'b1;
      FULL         <= 1'b0;
      ALMOST_EMPTY <= 1'b1;
      ALMOST_FULL  <= 1'b0;
      OVERFLOW     <= 1'b0;
      UNDERFLOW    <= 1'b0;
      data_q       <= '0;
    end else begin
      wr_ptr       <= wr_ptr_n;
      rd_ptr       <= rd_ptr_n;
      count        <= cnt_n;
      EMPTY        <= cnt_n == '0;
      FULL         <= cnt_n == PW'(D);
      ALMOST_EMPTY <= cnt_n <= PW'(AE_THRESH);
      ALMOST_FULL  <= cnt_n >= PW'(AF_THRESH);
      OVERFLOW     <= wr_en & ~wr_acc;
      UNDERFLOW    <= rd_en & EMPTY;
      data_q       <= ((FWFT == FIFO_FWFT) ? ~EMPTY : rd_acc) ? rdata : data_q;
    end
  end
  assign data_out = (FWFT == FIFO_FWFT && !EMPTY) ? rdata : data_q;
endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parametrised single-clock FIFO that succeeds the basic myfifo buffer. It adds configurable width and depth, an occupancy count, almost-full and almost-empty thresholds, overflow and underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode. It sits between producer and consumer blocks in the same clock domain, for example stream buffering ahead of a UART or SPI engine.

Parameters:
W, 8, data width in bits
D, 16, depth in words; must be a power of two and at least 4
AF_THRESH, D-2, ALMOST_FULL asserts when count >= AF_THRESH
AE_THRESH, 2, ALMOST_EMPTY asserts when count <= AE_THRESH
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
wr_en  in  1  write request
data_in  in  W  write data
rd_en  in  1  read request (in FWFT mode: acknowledge/pop of the head word)
data_out  out  W  read data
FULL  out  1  count == D
EMPTY  out  1  count == 0
ALMOST_FULL  out  1  count >= AF_THRESH
ALMOST_EMPTY  out  1  count <= AE_THRESH
count  out  $clog2(D)+1  current occupancy, 0..D
OVERFLOW  out  1  one-cycle pulse when a write is rejected
UNDERFLOW  out  1  one-cycle pulse when a read is rejected

Behaviour:
- Reset, sampled on the clk edge while rst=1:
  - wr_ptr=0, rd_ptr=0, count=0.
  - EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=0.
  - OVERFLOW=0, UNDERFLOW=0, data_out=0.
  - Memory contents are not cleared.
- Reset mid-operation discards all stored words. Flags return to their reset values on the next edge. rst has priority over wr_en and rd_en.
- Pointers are $clog2(D)+1 bits: the low bits address memory and the MSB is the wrap bit. count = wr_ptr - rd_ptr, computed modulo 2^($clog2(D)+1). Wrap from index D-1 to 0 is seamless.
- Acceptance rules:
  - wr_acc = wr_en & (!FULL | rd_acc)
  - rd_acc = rd_en & !EMPTY
- Rejected requests:
  - wr_en & !wr_acc -> OVERFLOW=1 for the following cycle. FIFO state is unchanged.
  - rd_en & EMPTY -> UNDERFLOW=1 for the following cycle. data_out holds its value.
- Simultaneous events:
  - Full and rd+wr: both accepted, count stays D, FULL stays 1.
  - Empty and rd+wr: write accepted, read rejected (UNDERFLOW pulse), count becomes 1.
- All flags and count are registered and reflect the state after the current edge, so they are valid in the cycle following the operation. There is no combinational path from inputs to flags.
- Standard mode (FWFT=0):
  - data_out updates one cycle after rd_acc with mem[rd_ptr].
  - data_out holds its value otherwise.
  - Read latency is 1 clock.
- FWFT mode (FWFT=1):
  - data_out always presents mem[rd_ptr] whenever EMPTY=0.
  - rd_acc pops the head, and the next word appears in the same cycle the pointer advances.
  - A write into an empty FIFO is visible on data_out 1 cycle after the write edge, when EMPTY falls.
  - When EMPTY=1, data_out holds its last value.
- AF_THRESH and AE_THRESH are compared against the registered count. Both flags may be asserted together for small D.

Decomposition:
- Package fifo_pkg holds:
  - a clog2 helper function
  - the pointer-width localparam
  - mode constants FIFO_STD=0 and FIFO_FWFT=1
- Sub-module fifo_ram, a simple dual-port register array:
  - one write port (we, waddr, wdata)
  - one asynchronous read port (raddr, rdata)
  - parameters W and D
- The top level holds the pointers, count, flag registers, and the FWFT/standard output muxing.

Test Plan:
- Reset then rd_en=1 for 3 cycles with W=4, D=4 -> EMPTY=1 throughout, UNDERFLOW pulses each cycle, count=0, data_out=0.
- Write 1,2,3,4 then one more write of 5 -> FULL=1 after the 4th write, ALMOST_FULL=1 at count=2, OVERFLOW pulses once, count stays 4. Reading back in standard mode yields 1,2,3,4, each 1 cycle after its rd_en.
- At FULL, drive wr_en=1 and rd_en=1 with data 9 -> count stays 4, no OVERFLOW, data_out=1. The next four reads return 2,3,4,9, proving the pointer wrapped.
- At EMPTY, drive wr_en=1 and rd_en=1 with data 7 -> count=1, UNDERFLOW pulses, EMPTY falls. The next read returns 7.
- With FWFT=1, write 0xA to an empty FIFO -> data_out=0xA as soon as EMPTY=0, with no rd_en. rd_en=1 for one cycle -> EMPTY=1 and count=0.
- Fill to 3, then assert rst for 1 cycle while wr_en=1 -> count=0, EMPTY=1, FULL=0, OVERFLOW=0, and the write is not captured.
